palette_loader: RTL and testbench

- Bus initiator that writes 16-bit 1BGR colours into the colour mixer's palette RAM (CRAM).
- Drives the same CPU-side pins the mixer responds to (ADDR, DATA, NRD, CRAMCS, WRP). It is the writer at the other end of the mixer's palette read path.
- Colours arrive on a valid/ready stream. The block splits each colour into two byte writes and steps through a programmable index range.
- Sits beside the CPU bus arbiter. It is used for boot-time palette fills and fades without CPU involvement.

---
 rtl/palette_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_palette_loader.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_loader.sv
`default_nettype none
// ============================================================================
//  Module      : palette_loader
//  Description : Bus initiator that fills the colour mixer's palette RAM.
//                Colours (16-bit 1BGR) arrive on a valid/ready stream; each
//                is split into two byte writes (high byte at the even address,
//                low byte at the odd address) driven onto the mixer's CPU-side
//                pins, while the colour index steps through a programmed range
//                that wraps 511 -> 0.
//
//  Ports       : CLK6 / RST           clock, synchronous active-high reset
//                START, BASE_IDX,     transfer request with first index and
//                COUNT                number of colours (0..512)
//                SRC_VALID/READY,     colour stream
//                SRC_COLOR
//                NCBLK                composite blank (active low) used when
//                                     BLANK_ONLY=1 to gate new byte cycles
//                ADDR, DATA_OUT,      CRAM bus: byte address {idx, byte_sel},
//                DATA_OE, DATA_IN,    write data + tri-state enable, readback,
//                NRD, CRAMCS, WRP     read strobe, select, write strobe
//                BUSY, DONE           transfer status
//                ERR, ERR_IDX         sticky readback mismatch + first index
//
//  Options     : define PALETTE_LOADER_VERIFY_EN to read back and compare both
//                bytes of every colour after writing them.
//
//  Revision    : 1.0  initial release
// ============================================================================
module palette_loader #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int BLANK_ONLY = 0
) (
    input  logic        CLK6,
    input  logic        RST,
    input  logic        START,
    input  logic [8:0]  BASE_IDX,
    input  logic [9:0]  COUNT,
    input  logic        SRC_VALID,
    output logic        SRC_READY,
    input  logic [15:0] SRC_COLOR,
    input  logic        NCBLK,
    output logic [9:0]  ADDR,
    output logic [7:0]  DATA_OUT,
    output logic        DATA_OE,
    input  logic [7:0]  DATA_IN,
    output logic        NRD,
    output logic        CRAMCS,
    output logic        WRP,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [8:0]  ERR_IDX
);

`ifdef PALETTE_LOADER_VERIFY_EN
    localparam logic c_VERIFY = 1'b1;
`else
    localparam logic c_VERIFY = 1'b0;
`endif

    // S_HOLDOFF parks the bus between byte cycles while blanking forbids a
    // new one; the pending cycle kind (write or readback) is held in r_rd.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_HOLDOFF   = 4'd2,
        S_SETUP     = 4'd3,
        S_STROBE    = 4'd4,
        S_HOLD      = 4'd5,
        S_GAP       = 4'd6,
        S_RD_SETUP  = 4'd7,
        S_RD_STROBE = 4'd8,
        S_FINISH    = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;       // cycles spent in the current timed state
    logic [8:0]  r_idx;
    logic [9:0]  r_rem;
    logic [14:0] r_color;     // bit 15 of the source colour is dropped
    logic        r_sel;       // byte_sel: 0 = high byte, 1 = low byte
    logic        r_rd;        // 1 while the readback pair is in progress
    logic        r_err;
    logic [8:0]  r_err_idx;

    logic        w_gate;
    logic        w_last;
    logic        w_rd_mismatch;

    assign w_gate = (BLANK_ONLY != 0) && NCBLK;

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_SETUP, S_RD_SETUP:   w_last = (r_cnt == 8'(SETUP_CYC - 1));
            S_STROBE, S_RD_STROBE: w_last = (r_cnt == 8'(STROBE_CYC - 1));
            S_HOLD:                w_last = (r_cnt == 8'(HOLD_CYC - 1));
            default:               w_last = 1'b0;
        endcase
    end

`ifdef PALETTE_LOADER_VERIFY_EN
    // Bit 7 of the high byte is not stored in CRAM, so it is not compared.
    assign w_rd_mismatch = r_sel ? (DATA_IN != r_color[7:0])
                                 : (DATA_IN[6:0] != r_color[14:8]);
`else
    logic w_unused_data_in;
    assign w_unused_data_in = ^DATA_IN;
    assign w_rd_mismatch    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK6) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next == r_state) ? r_cnt + 8'd1 : 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next = (COUNT == 10'd0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (SRC_VALID) begin
                    w_next = w_gate ? S_HOLDOFF : S_SETUP;
                end
            end
            S_HOLDOFF: begin
                if (!w_gate) begin
                    w_next = r_rd ? S_RD_SETUP : S_SETUP;
                end
            end
            S_SETUP:     if (w_last) w_next = S_STROBE;
            S_STROBE:    if (w_last) w_next = S_HOLD;
            S_HOLD:      if (w_last) w_next = S_GAP;
            S_RD_SETUP:  if (w_last) w_next = S_RD_STROBE;
            S_RD_STROBE: if (w_last) w_next = S_GAP;
            S_GAP: begin
                if (!r_sel) begin
                    // second byte of the same pass (write or readback)
                    if (w_gate)    w_next = S_HOLDOFF;
                    else if (r_rd) w_next = S_RD_SETUP;
                    else           w_next = S_SETUP;
                end else if (c_VERIFY && !r_rd) begin
                    w_next = w_gate ? S_HOLDOFF : S_RD_SETUP;
                end else if (r_rem == 10'd1) begin
                    w_next = S_FINISH;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK6) begin
        if (RST) begin
            r_idx     <= 9'd0;
            r_rem     <= 10'd0;
            r_color   <= 15'd0;
            r_sel     <= 1'b0;
            r_rd      <= 1'b0;
            r_err     <= 1'b0;
            r_err_idx <= 9'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_idx     <= BASE_IDX;
                        r_rem     <= COUNT;
                        r_err     <= 1'b0;
                        r_err_idx <= 9'd0;
                    end
                end
                S_FETCH: begin
                    if (SRC_VALID) begin
                        r_color <= SRC_COLOR[14:0];
                        r_sel   <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (!r_sel) begin
                        r_sel <= 1'b1;
                    end else if (c_VERIFY && !r_rd) begin
                        r_rd  <= 1'b1;
                        r_sel <= 1'b0;
                    end else begin
                        r_rd  <= 1'b0;
                        r_idx <= r_idx + 9'd1;
                        r_rem <= r_rem - 10'd1;
                    end
                end
                S_RD_STROBE: begin
                    // only the first mismatch of a transfer is recorded
                    if (w_last && w_rd_mismatch && !r_err) begin
                        r_err     <= 1'b1;
                        r_err_idx <= r_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pure decode of registered state, no path from SRC_VALID
    // ------------------------------------------------------------------
    assign SRC_READY = (r_state == S_FETCH);
    assign ADDR      = {r_idx, r_sel};
    assign DATA_OUT  = r_sel ? r_color[7:0] : {1'b0, r_color[14:8]};
    assign DATA_OE   = (r_state == S_SETUP) || (r_state == S_STROBE) ||
                       (r_state == S_HOLD);
    assign CRAMCS    = DATA_OE || (r_state == S_RD_SETUP) ||
                       (r_state == S_RD_STROBE);
    assign WRP       = (r_state != S_STROBE);
    assign NRD       = !((r_state == S_RD_SETUP) || (r_state == S_RD_STROBE));
    assign BUSY      = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign DONE      = (r_state == S_FINISH);
    assign ERR       = r_err;
    assign ERR_IDX   = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_palette_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palette_loader
//  Description : Self-checking bench for palette_loader. A bus monitor
//                captures every CRAM write into a byte-wide memory model and
//                checks strobe protocol; each test compares the captured
//                write list against addresses/data computed from the colour
//                list by index arithmetic. DATA_IN is served from the memory
//                model with optional corruption of indices 7 and 9.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_palette_loader;

    localparam int STROBE = 2;
`ifdef PALETTE_LOADER_VERIFY_EN
    localparam int DONE_LAT = 20;
`else
    localparam int DONE_LAT = 12;
`endif

    logic        CLK6 = 1'b0;
    logic        RST, START, SRC_VALID, NCBLK;
    logic [8:0]  BASE_IDX;
    logic [9:0]  COUNT;
    logic [15:0] SRC_COLOR;
    logic [7:0]  DATA_IN;
    logic        SRC_READY, DATA_OE, NRD, CRAMCS, WRP, BUSY, DONE, ERR;
    logic [9:0]  ADDR;
    logic [7:0]  DATA_OUT;
    logic [8:0]  ERR_IDX;

    always #5 CLK6 = ~CLK6;

    palette_loader #(
        .SETUP_CYC (1),
        .STROBE_CYC(STROBE),
        .HOLD_CYC  (1),
        .BLANK_ONLY(1)
    ) dut (
        .CLK6     (CLK6),
        .RST      (RST),
        .START    (START),
        .BASE_IDX (BASE_IDX),
        .COUNT    (COUNT),
        .SRC_VALID(SRC_VALID),
        .SRC_READY(SRC_READY),
        .SRC_COLOR(SRC_COLOR),
        .NCBLK    (NCBLK),
        .ADDR     (ADDR),
        .DATA_OUT (DATA_OUT),
        .DATA_OE  (DATA_OE),
        .DATA_IN  (DATA_IN),
        .NRD      (NRD),
        .CRAMCS   (CRAMCS),
        .WRP      (WRP),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .ERR_IDX  (ERR_IDX)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // monitor state and logs
    logic [7:0]  mem [0:1023];
    logic [9:0]  wr_addr[$];
    logic [7:0]  wr_data[$];
    int          wr_cyc[$];
    int          done_cyc[$];
    int          viol, cs_cnt, rdy_cnt, run;
    bit          prev_wrp = 1'b1;
    bit          acc = 1'b0;
    bit          corrupt_en = 1'b0;

    // colour source
    logic [15:0] src_col[$];
    int          src_pos;
    bit          src_en, stall_rand;

    assign DATA_IN = mem[ADDR] ^ {7'd0, corrupt_en &&
                                  (ADDR[9:1] == 9'd7 || ADDR[9:1] == 9'd9)};

    always @(posedge CLK6) cyc <= cyc + 1;

    always @(negedge CLK6) begin
        acc = SRC_VALID && SRC_READY && !RST;
        if (RST) begin
            prev_wrp = 1'b1;
            run      = 0;
        end else begin
            if (!WRP && !CRAMCS) viol++;
            if (DATA_OE && !NRD) viol++;
            if (!WRP && prev_wrp) begin
                wr_addr.push_back(ADDR);
                wr_data.push_back(DATA_OUT);
                wr_cyc.push_back(cyc);
                mem[ADDR] = DATA_OUT;
            end
            if (!WRP) run++;
            else if (run != 0) begin
                if (run != STROBE) viol++;
                run = 0;
            end
            if (DONE)      done_cyc.push_back(cyc);
            if (CRAMCS)    cs_cnt++;
            if (SRC_READY) rdy_cnt++;
            prev_wrp = WRP;
        end
    end

    task automatic upd_src();
        bit en;
        en = src_en && (!stall_rand || ($urandom_range(0, 2) != 0));
        SRC_VALID = en && (src_pos < src_col.size());
        SRC_COLOR = (src_pos < src_col.size()) ? src_col[src_pos] : 16'h0000;
    endtask

    task automatic tick();
        @(posedge CLK6);
        #1;
        if (acc) src_pos++;
        upd_src();
    endtask

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
        viol = 0; cs_cnt = 0; rdy_cnt = 0;
    endtask

    task automatic fill_src(input int n);
        src_col.delete();
        for (int k = 0; k < n; k++) src_col.push_back(16'($urandom));
        src_pos = 0;
    endtask

    task automatic start_xfer(input logic [8:0] base, input int cnt, output int t0);
        clear_logs();
        upd_src();
        BASE_IDX = base;
        COUNT    = 10'(cnt);
        START    = 1'b1;
        t0       = cyc;
        tick();
        START    = 1'b0;
    endtask

    // Waits for DONE and checks the captured write list against the colours.
    task automatic finish_xfer(input logic [8:0] base, input int cnt, input string tag);
        int         w;
        logic [8:0] ix;
        logic [15:0] c;
        logic [9:0] ga, ea;
        logic [7:0] gd, ed;
        w = 0;
        while (done_cyc.size() == 0 && w < cnt * 40 + 60) begin
            tick();
            w++;
        end
        repeat (3) tick();
        total++;
        if (done_cyc.size() !== 1) begin
            bad++;
            $display("FAIL %s done_count: got %0d want 1", tag, done_cyc.size());
        end
        total++;
        if (wr_addr.size() !== 2 * cnt) begin
            bad++;
            $display("FAIL %s write_count: got %0d want %0d", tag, wr_addr.size(), 2 * cnt);
        end
        for (int k = 0; k < 2 * cnt; k++) begin
            ix = 9'((int'(base) + k / 2) % 512);
            c  = src_col[k / 2];
            ea = {ix, k[0]};
            ed = k[0] ? c[7:0] : {1'b0, c[14:8]};
            ga = (k < wr_addr.size()) ? wr_addr[k] : 10'bx;
            gd = (k < wr_data.size()) ? wr_data[k] : 8'bx;
            total++;
            if ({ga, gd} !== {ea, ed}) begin
                bad++;
                $display("FAIL %s write%0d: got addr=%h data=%h want addr=%h data=%h",
                         tag, k, ga, gd, ea, ed);
            end
        end
        total++;
        if (viol !== 0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL %s protocol: got violations=%0d busy=%b want 0/0", tag, viol, BUSY);
        end
        if (done_cyc.size() == 0) begin
            RST = 1'b1; tick(); RST = 1'b0; tick();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; NCBLK = 1'b0; BASE_IDX = '0; COUNT = '0;
        src_en = 1'b0; stall_rand = 1'b0; src_col.delete(); src_pos = 0;
        upd_src();
        repeat (3) tick();
        total++;
        if ({SRC_READY, ADDR, DATA_OUT, DATA_OE, NRD, CRAMCS, WRP, BUSY, DONE, ERR, ERR_IDX}
            !== {1'b0, 10'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0}) begin
            bad++;
            $display("FAIL reset_values: got rdy=%b addr=%h d=%h oe=%b nrd=%b cs=%b wrp=%b busy=%b done=%b err=%b eidx=%h want 0 000 00 0 1 0 1 0 0 0 000",
                     SRC_READY, ADDR, DATA_OUT, DATA_OE, NRD, CRAMCS, WRP, BUSY, DONE, ERR, ERR_IDX);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single_colour();
        int t0;
        src_col.delete(); src_col.push_back(16'hFBCD); src_pos = 0;
        src_en = 1'b1; stall_rand = 1'b0;
        start_xfer(9'd5, 1, t0);
        finish_xfer(9'd5, 1, "single");
        total++;
        if (wr_data.size() < 2 || wr_data[0] !== 8'h7B || wr_data[1] !== 8'hCD) begin
            bad++;
            $display("FAIL single_bytes: got %0d writes first=%h want 7B then CD",
                     wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 8'hxx);
        end
        total++;
        if (wr_cyc.size() < 2 || wr_cyc[0] - t0 !== 3 || wr_cyc[1] - t0 !== 8) begin
            bad++;
            $display("FAIL single_strobe_cycles: got %0d/%0d want 3/8",
                     (wr_cyc.size() > 0) ? wr_cyc[0] - t0 : -1,
                     (wr_cyc.size() > 1) ? wr_cyc[1] - t0 : -1);
        end
        total++;
        if (done_cyc.size() < 1 || done_cyc[0] - t0 !== DONE_LAT) begin
            bad++;
            $display("FAIL single_done_cycle: got %0d want %0d",
                     (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1, DONE_LAT);
        end
    endtask

    task automatic test_wrap();
        int t0;
        fill_src(2); src_en = 1'b1; stall_rand = 1'b0;
        start_xfer(9'd511, 2, t0);
        finish_xfer(9'd511, 2, "wrap");
        total++;
        if (wr_addr.size() < 3 || wr_addr[2] !== 10'h000 || ERR !== 1'b0) begin
            bad++;
            $display("FAIL wrap_addr: got addr=%h err=%b want 000/0",
                     (wr_addr.size() > 2) ? wr_addr[2] : 10'hxxx, ERR);
        end
    endtask

    task automatic test_zero_count();
        int t0;
        src_col.delete(); src_pos = 0; src_en = 1'b1;
        start_xfer(9'd33, 0, t0);
        repeat (5) tick();
        total++;
        if (done_cyc.size() !== 1 || done_cyc[0] - t0 < 1 || done_cyc[0] - t0 > 2) begin
            bad++;
            $display("FAIL zero_done: got %0d pulses first_at=%0d want 1 pulse at 1..2",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1);
        end
        total++;
        if (cs_cnt !== 0 || rdy_cnt !== 0) begin
            bad++;
            $display("FAIL zero_bus: got cs_cycles=%0d ready_cycles=%0d want 0/0", cs_cnt, rdy_cnt);
        end
    endtask

    task automatic test_stall_and_restart();
        int t0;
        fill_src(2); src_en = 1'b0; stall_rand = 1'b0;
        start_xfer(9'd20, 2, t0);
        repeat (20) tick();
        total++;
        if (cs_cnt !== 0 || rdy_cnt !== 20 || SRC_READY !== 1'b1) begin
            bad++;
            $display("FAIL stall_idle: got cs=%0d ready_cycles=%0d ready=%b want 0/20/1",
                     cs_cnt, rdy_cnt, SRC_READY);
        end
        // START while busy must not disturb the running transfer
        BASE_IDX = 9'd300; COUNT = 10'd1; START = 1'b1; src_en = 1'b1;
        tick();
        START = 1'b0;
        finish_xfer(9'd20, 2, "stall");
    endtask

    task automatic test_blank_gate();
        int t0, w, n;
        fill_src(1); src_en = 1'b1; stall_rand = 1'b0;
        NCBLK = 1'b1;
        start_xfer(9'd100, 1, t0);
        repeat (30) tick();
        total++;
        if (cs_cnt !== 0 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL blank_holdoff: got cs=%0d busy=%b want 0/1", cs_cnt, BUSY);
        end
        NCBLK = 1'b0;
        w = 0;
        while (WRP !== 1'b0 && w < 10) begin tick(); w++; end
        NCBLK = 1'b1;
        w = 0;
        while (WRP !== 1'b1 && w < 10) begin tick(); w++; end
        repeat (6) tick();
        n = cs_cnt;
        repeat (5) tick();
        total++;
        if (wr_addr.size() !== 1 || cs_cnt !== n || viol !== 0) begin
            bad++;
            $display("FAIL blank_mid_strobe: got writes=%0d cs_delta=%0d viol=%0d want 1/0/0",
                     wr_addr.size(), cs_cnt - n, viol);
        end
        NCBLK = 1'b0;
        finish_xfer(9'd100, 1, "blank");
    endtask

    task automatic test_reset_mid();
        int t0, w;
        fill_src(3); src_en = 1'b1; stall_rand = 1'b0;
        start_xfer(9'd50, 3, t0);
        w = 0;
        while (WRP !== 1'b0 && w < 20) begin tick(); w++; end
        RST = 1'b1;
        tick();
        total++;
        if ({WRP, CRAMCS, BUSY, SRC_READY, DONE, DATA_OE} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_mid: got wrp=%b cs=%b busy=%b rdy=%b done=%b oe=%b want 1 0 0 0 0 0",
                     WRP, CRAMCS, BUSY, SRC_READY, DONE, DATA_OE);
        end
        RST = 1'b0;
        src_col.delete(); src_pos = 0;
        tick();
    endtask

    task automatic test_verify();
        int t0;
        fill_src(6); src_en = 1'b1; stall_rand = 1'b0;
        corrupt_en = 1'b1;
        start_xfer(9'd4, 6, t0);
        finish_xfer(9'd4, 6, "verify_bad");
        corrupt_en = 1'b0;
        total++;
`ifdef PALETTE_LOADER_VERIFY_EN
        if (ERR !== 1'b1 || ERR_IDX !== 9'd7) begin
            bad++;
            $display("FAIL verify_err: got err=%b idx=%0d want 1/7", ERR, ERR_IDX);
        end
`else
        if (ERR !== 1'b0 || ERR_IDX !== 9'd0) begin
            bad++;
            $display("FAIL verify_err: got err=%b idx=%0d want 0/0", ERR, ERR_IDX);
        end
`endif
        fill_src(1);
        start_xfer(9'd200, 1, t0);
        finish_xfer(9'd200, 1, "verify_clean");
        total++;
        if (ERR !== 1'b0) begin
            bad++;
            $display("FAIL verify_clear: got err=%b want 0", ERR);
        end
    endtask

    task automatic test_back_to_back();
        int t0, n;
        logic [8:0] b;
        stall_rand = 1'b1; src_en = 1'b1;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, 5);
            b = (it == 2) ? 9'd509 : 9'($urandom_range(0, 511));
            fill_src(n);
            start_xfer(b, n, t0);
            finish_xfer(b, n, "b2b");
        end
        stall_rand = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
        test_reset();
        test_single_colour();
        test_wrap();
        test_zero_count();
        test_stall_and_restart();
        test_blank_gate();
        test_reset_mid();
        test_verify();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
